// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the hex 7-segment scanner.
package seg7_pkg;

  // Segment bit order: bit0 = a ... bit6 = g, active-high.
  localparam logic [6:0] SEG_OFF = 7'h00;

  localparam logic [6:0] SEG7_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Decoded pattern for one digit before polarity is applied.
  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
  } seg7_out_t;

  function automatic logic [6:0] hex_to_seg7(input logic [3:0] nibble);
    return SEG7_TABLE[nibble];
  endfunction

endpackage

// File: rtl/hex_display_scanner_if.sv
// Bus between the value source and the display scanner.
//
// Load is a one-cycle write qualifier with no back-pressure: whenever Load is
// high at a rising clock edge the scanner accepts Value/DotIn, so there is no
// ready signal. Enable is a level, not a handshake.
interface hex_display_scanner_if #(
  parameter int NUM_DIGITS = 4
) ();
  logic [4*NUM_DIGITS-1:0] Value;
  logic [NUM_DIGITS-1:0]   DotIn;
  logic                    Load;
  logic                    Enable;
  logic [6:0]              Seg;
  logic                    Dp;
  logic [NUM_DIGITS-1:0]   DigitEn;
  logic                    FrameTick;

  modport master (
    output Value, DotIn, Load, Enable,
    input  Seg, Dp, DigitEn, FrameTick
  );

  modport slave (
    input  Value, DotIn, Load, Enable,
    output Seg, Dp, DigitEn, FrameTick
  );
endinterface

// File: rtl/seg7_digit_mux.sv
// Selects the nibble/dot of the scanned digit, applies leading-zero blanking
// and decodes to active-high segments. Purely combinational.
module seg7_digit_mux
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS         = 4,
  parameter int LEADING_ZERO_BLANK = 0,
  parameter int IDX_W              = 2
) (
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dots,
  input  logic [IDX_W-1:0]        index,
  output seg7_out_t               out
);

  logic [NUM_DIGITS-1:0] keep;
  logic                  higher;
  logic [3:0]            nibble;
  logic                  dot;
  logic                  kept;

  // A digit is significant when it, or any higher digit, is non-zero or has
  // its dot set; digit 0 always shows.
  always_comb begin
    keep   = '0;
    higher = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      higher  = higher | (value[4*i +: 4] != 4'h0) | dots[i];
      keep[i] = higher;
    end
    keep[0] = 1'b1;
  end

  // Pick the scanned digit and decode it.
  always_comb begin
    nibble = 4'h0;
    dot    = 1'b0;
    kept   = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (index == IDX_W'(i)) begin
        nibble = value[4*i +: 4];
        dot    = dots[i];
        kept   = keep[i];
      end
    end
    out.dp  = dot;
    out.seg = ((LEADING_ZERO_BLANK != 0) && !kept) ? SEG_OFF : hex_to_seg7(nibble);
  end

endmodule

// File: rtl/hex_display_scanner.sv
// Time-multiplexed N-digit hex display driver with frame-synchronous updates.
module hex_display_scanner
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS         = 4,
  parameter int SCAN_DIV           = 50000,
  parameter int INVERT_SEGMENTS    = 0,
  parameter int INVERT_DIGITS      = 0,
  parameter int LEADING_ZERO_BLANK = 0
) (
  input logic                  clock,
  input logic                  reset,
  hex_display_scanner_if.slave bus
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  // XOR masks turning active-high patterns into pin polarity.
  localparam logic [6:0]            SEG_POL = (INVERT_SEGMENTS != 0) ? 7'h7F : 7'h00;
  localparam logic                  DP_POL  = (INVERT_SEGMENTS != 0);
  localparam logic [NUM_DIGITS-1:0] DIG_POL = {NUM_DIGITS{INVERT_DIGITS != 0}};

  logic [DIV_W-1:0]        presc;
  logic [IDX_W-1:0]        index;
  logic                    tick;
  logic                    wrap;
  logic [4*NUM_DIGITS-1:0] shadow_value;
  logic [NUM_DIGITS-1:0]   shadow_dots;
  logic                    pending;
  logic [4*NUM_DIGITS-1:0] disp_value;
  logic [NUM_DIGITS-1:0]   disp_dots;
  logic [NUM_DIGITS-1:0]   onehot;
  seg7_out_t               mux_out;
  logic [6:0]              seg_q;
  logic                    dp_q;
  logic [NUM_DIGITS-1:0]   dig_q;
  logic                    frame_q;

  assign tick = (presc == DIV_LAST);
  assign wrap = tick && (index == IDX_LAST);

  // Prescaler, digit index and the frame pulse that marks the wrap to digit 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      presc   <= '0;
      index   <= '0;
      frame_q <= 1'b0;
    end else begin
      frame_q <= wrap;
      if (tick) begin
        presc <= '0;
        index <= wrap ? '0 : index + IDX_W'(1);
      end else begin
        presc <= presc + DIV_W'(1);
      end
    end
  end

  // Loads land in the shadow; the display copy only changes on the wrap tick
  // so a frame is never torn. A load on the wrap tick itself goes straight in.
  always_ff @(posedge clock) begin
    if (reset) begin
      shadow_value <= '0;
      shadow_dots  <= '0;
      pending      <= 1'b0;
      disp_value   <= '0;
      disp_dots    <= '0;
    end else if (wrap) begin
      pending <= 1'b0;
      if (bus.Load) begin
        disp_value <= bus.Value;
        disp_dots  <= bus.DotIn;
      end else if (pending) begin
        disp_value <= shadow_value;
        disp_dots  <= shadow_dots;
      end
    end else if (bus.Load) begin
      shadow_value <= bus.Value;
      shadow_dots  <= bus.DotIn;
      pending      <= 1'b1;
    end
  end

  // One-hot strobe for the scanned digit.
  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      onehot[i] = (index == IDX_W'(i));
    end
  end

  seg7_digit_mux #(
    .NUM_DIGITS         (NUM_DIGITS),
    .LEADING_ZERO_BLANK (LEADING_ZERO_BLANK),
    .IDX_W              (IDX_W)
  ) u_mux (
    .value (disp_value),
    .dots  (disp_dots),
    .index (index),
    .out   (mux_out)
  );

  // Registered pin drivers; dark (off level) during reset or when disabled.
  always_ff @(posedge clock) begin
    if (reset || !bus.Enable) begin
      seg_q <= SEG_OFF ^ SEG_POL;
      dp_q  <= DP_POL;
      dig_q <= DIG_POL;
    end else begin
      seg_q <= mux_out.seg ^ SEG_POL;
      dp_q  <= mux_out.dp ^ DP_POL;
      dig_q <= onehot ^ DIG_POL;
    end
  end

  assign bus.Seg       = seg_q;
  assign bus.Dp        = dp_q;
  assign bus.DigitEn   = dig_q;
  assign bus.FrameTick = frame_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Bench for hex_display_scanner: four configurations side by side, each
// tracked by a cycle-count reference model plus directed literal checks.
module tb_hex_display_scanner;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  // Per-instance configuration: 0 plain, 1 blanking, 2 inverted, 3 single digit fast.
  int p_n    [4] = '{4, 4, 4, 1};
  int p_div  [4] = '{4, 4, 4, 1};
  int p_lzb  [4] = '{0, 1, 0, 0};
  int p_invs [4] = '{0, 0, 1, 0};
  int p_invd [4] = '{0, 0, 1, 0};

  logic [31:0] val_in  [4];
  logic [7:0]  dot_in  [4];
  logic        load_in [4];
  logic        en_in   [4];

  logic [16:0] obs   [4];
  logic [16:0] exp_v [4];

  int n_checks = 0;
  int n_errors = 0;

  logic [6:0] seg_tab [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  hex_display_scanner_if #(.NUM_DIGITS(4)) b0 ();
  hex_display_scanner_if #(.NUM_DIGITS(4)) b1 ();
  hex_display_scanner_if #(.NUM_DIGITS(4)) b2 ();
  hex_display_scanner_if #(.NUM_DIGITS(1)) b3 ();

  assign b0.Value = val_in[0][15:0];
  assign b0.DotIn = dot_in[0][3:0];
  assign b0.Load = load_in[0];
  assign b0.Enable = en_in[0];
  assign b1.Value = val_in[1][15:0];
  assign b1.DotIn = dot_in[1][3:0];
  assign b1.Load = load_in[1];
  assign b1.Enable = en_in[1];
  assign b2.Value = val_in[2][15:0];
  assign b2.DotIn = dot_in[2][3:0];
  assign b2.Load = load_in[2];
  assign b2.Enable = en_in[2];
  assign b3.Value = val_in[3][3:0];
  assign b3.DotIn = dot_in[3][0];
  assign b3.Load = load_in[3];
  assign b3.Enable = en_in[3];

  assign obs[0] = {b0.Seg, b0.Dp, 8'(b0.DigitEn), b0.FrameTick};
  assign obs[1] = {b1.Seg, b1.Dp, 8'(b1.DigitEn), b1.FrameTick};
  assign obs[2] = {b2.Seg, b2.Dp, 8'(b2.DigitEn), b2.FrameTick};
  assign obs[3] = {b3.Seg, b3.Dp, 8'(b3.DigitEn), b3.FrameTick};

  hex_display_scanner #(.NUM_DIGITS(4), .SCAN_DIV(4), .INVERT_SEGMENTS(0),
    .INVERT_DIGITS(0), .LEADING_ZERO_BLANK(0)) dut0 (.clock(clock), .reset(reset), .bus(b0));
  hex_display_scanner #(.NUM_DIGITS(4), .SCAN_DIV(4), .INVERT_SEGMENTS(0),
    .INVERT_DIGITS(0), .LEADING_ZERO_BLANK(1)) dut1 (.clock(clock), .reset(reset), .bus(b1));
  hex_display_scanner #(.NUM_DIGITS(4), .SCAN_DIV(4), .INVERT_SEGMENTS(1),
    .INVERT_DIGITS(1), .LEADING_ZERO_BLANK(0)) dut2 (.clock(clock), .reset(reset), .bus(b2));
  hex_display_scanner #(.NUM_DIGITS(1), .SCAN_DIV(1), .INVERT_SEGMENTS(0),
    .INVERT_DIGITS(0), .LEADING_ZERO_BLANK(0)) dut3 (.clock(clock), .reset(reset), .bus(b3));

  // Reference model: time since reset determines which digit is up; the
  // display copy follows the shadow/commit rules at frame boundaries.
  int          m_cyc    [4];
  logic [31:0] m_disp   [4];
  logic [7:0]  m_ddot   [4];
  logic [31:0] m_shadow [4];
  logic [7:0]  m_sdot   [4];
  logic        m_pend   [4];

  always @(posedge clock) begin
    for (int k = 0; k < 4; k++) begin
      int         idx;
      logic       tick, wrap, blank;
      logic [6:0] seg;
      logic       dp, ft;
      logic [7:0] dig, dmask;
      logic [31:0] vmask;
      dmask = 8'((1 << p_n[k]) - 1);
      vmask = 32'((64'd1 << (4 * p_n[k])) - 64'd1);
      seg = 7'h00; dp = 1'b0; dig = 8'h00; ft = 1'b0;
      if (reset) begin
        m_cyc[k] = 0; m_disp[k] = '0; m_ddot[k] = '0;
        m_shadow[k] = '0; m_sdot[k] = '0; m_pend[k] = 1'b0;
      end else begin
        idx  = (m_cyc[k] / p_div[k]) % p_n[k];
        tick = ((m_cyc[k] % p_div[k]) == p_div[k] - 1);
        wrap = tick && (idx == p_n[k] - 1);
        ft   = wrap;
        if (en_in[k]) begin
          blank = (p_lzb[k] != 0) && (idx != 0) && ((m_disp[k] >> (4 * idx)) == 0)
                  && ((m_ddot[k] >> idx) == 0);
          seg = blank ? 7'h00 : seg_tab[4'(m_disp[k] >> (4 * idx))];
          dp  = m_ddot[k][idx];
          dig = 8'(1 << idx);
        end
        if (wrap) begin
          if (load_in[k]) begin
            m_disp[k] = val_in[k] & vmask; m_ddot[k] = dot_in[k] & dmask;
          end else if (m_pend[k]) begin
            m_disp[k] = m_shadow[k]; m_ddot[k] = m_sdot[k];
          end
          m_pend[k] = 1'b0;
        end else if (load_in[k]) begin
          m_shadow[k] = val_in[k] & vmask; m_sdot[k] = dot_in[k] & dmask;
          m_pend[k] = 1'b1;
        end
        m_cyc[k] = m_cyc[k] + 1;
      end
      if (p_invs[k] != 0) begin
        seg = ~seg; dp = ~dp;
      end
      if (p_invd[k] != 0) dig = ~dig & dmask;
      exp_v[k] = {seg, dp, dig, ft};
    end
  end

  // Driver: hold reset for some cycles, release just after a falling edge.
  task automatic do_reset(input int cycles);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      load_in[k] = 1'b0; en_in[k] = 1'b1; dot_in[k] = '0; val_in[k] = '0;
    end
    repeat (cycles) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (obs[k] !== exp_v[k]) begin
        n_errors++; $display("FAIL reset_model dut%0d got=%h exp=%h", k, obs[k], exp_v[k]);
      end
    end
    n_checks++;
    if (obs[0] !== 17'h0) begin
      n_errors++; $display("FAIL reset_off_plain got=%h exp=%h", obs[0], 17'h0);
    end
    n_checks++;
    if (obs[2] !== {7'h7F, 1'b1, 8'h0F, 1'b0}) begin
      n_errors++; $display("FAIL reset_off_inv got=%h exp=%h", obs[2], {7'h7F, 1'b1, 8'h0F, 1'b0});
    end
    reset = 1'b0;
    @(negedge clock);
    n_checks++;
    if ({b0.Seg, b0.DigitEn} !== {7'h3F, 4'b0001}) begin
      n_errors++; $display("FAIL first_lit got=%h exp=%h", {b0.Seg, b0.DigitEn}, {7'h3F, 4'b0001});
    end
  endtask

  // Scan order, frame-synchronous update, last-load-wins, load on wrap tick.
  task automatic test_scan();
    logic [6:0] tab [4][4] = '{'{7'h3F, 7'h3F, 7'h3F, 7'h3F}, '{7'h66, 7'h4F, 7'h5B, 7'h06},
                               '{7'h5E, 7'h39, 7'h7C, 7'h77}, '{7'h71, 7'h3F, 7'h77, 7'h6D}};
    do_reset(2);
    for (int e = 0; e < 96; e++) begin
      int fs, d;
      logic [11:0] want;
      load_in[0] = (e == 0) || (e == 40) || (e == 41) || (e == 79);
      val_in[0]  = (e == 0) ? 32'h1234 : (e == 40) ? 32'h0000 : (e == 41) ? 32'hABCD : 32'h5A0F;
      @(negedge clock);
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (obs[k] !== exp_v[k]) begin
          n_errors++; $display("FAIL scan_model dut%0d e=%0d got=%h exp=%h", k, e, obs[k], exp_v[k]);
        end
      end
      fs = (e < 16) ? 0 : (e < 48) ? 1 : (e < 80) ? 2 : 3;
      d  = (e % 16) / 4;
      want = {tab[fs][d], 4'(1 << d), (e % 16) == 15};
      n_checks++;
      if ({b0.Seg, b0.DigitEn, b0.FrameTick} !== want) begin
        n_errors++;
        $display("FAIL scan e=%0d got=%h exp=%h", e, {b0.Seg, b0.DigitEn, b0.FrameTick}, want);
      end
    end
    load_in[0] = 1'b0;
  endtask

  // Leading-zero blanking, including the dot that stops blanking.
  task automatic test_blanking();
    logic [6:0] tab [4][4] = '{'{7'h3F, 7'h00, 7'h00, 7'h00}, '{7'h3F, 7'h07, 7'h00, 7'h00},
                               '{7'h3F, 7'h00, 7'h00, 7'h00}, '{7'h3F, 7'h3F, 7'h3F, 7'h00}};
    do_reset(2);
    for (int e = 0; e < 64; e++) begin
      int d;
      logic [11:0] want;
      load_in[1] = (e == 0) || (e == 20) || (e == 36);
      val_in[1]  = (e == 0) ? 32'h0070 : 32'h0000;
      dot_in[1]  = (e == 36) ? 8'b0100 : 8'b0000;
      @(negedge clock);
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (obs[k] !== exp_v[k]) begin
          n_errors++; $display("FAIL lzb_model dut%0d e=%0d got=%h exp=%h", k, e, obs[k], exp_v[k]);
        end
      end
      d = (e % 16) / 4;
      want = {tab[e / 16][d], (e >= 48) && (d == 2), 4'(1 << d)};
      n_checks++;
      if ({b1.Seg, b1.Dp, b1.DigitEn} !== want) begin
        n_errors++; $display("FAIL lzb e=%0d got=%h exp=%h", e, {b1.Seg, b1.Dp, b1.DigitEn}, want);
      end
    end
    load_in[1] = 1'b0;
  endtask

  // Inverted polarity and Enable gating while the scan keeps running.
  task automatic test_polarity();
    do_reset(2);
    for (int e = 0; e < 40; e++) begin
      int d;
      logic [12:0] want;
      load_in[2] = (e == 0);
      val_in[2]  = 32'h0008;
      en_in[2]   = !((e >= 24) && (e < 36));
      @(negedge clock);
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (obs[k] !== exp_v[k]) begin
          n_errors++; $display("FAIL pol_model dut%0d e=%0d got=%h exp=%h", k, e, obs[k], exp_v[k]);
        end
      end
      d = (e % 16) / 4;
      if (en_in[2]) want = {((e >= 16) && (d == 0)) ? 7'h00 : 7'h40, 1'b1, ~4'(1 << d), (e % 16) == 15};
      else          want = {7'h7F, 1'b1, 4'hF, (e % 16) == 15};
      n_checks++;
      if ({b2.Seg, b2.Dp, b2.DigitEn, b2.FrameTick} !== want) begin
        n_errors++;
        $display("FAIL pol e=%0d got=%h exp=%h", e, {b2.Seg, b2.Dp, b2.DigitEn, b2.FrameTick}, want);
      end
    end
    en_in[2] = 1'b1; load_in[2] = 1'b0;
  endtask

  // One digit, divide-by-one: every cycle is a wrap tick.
  task automatic test_single();
    do_reset(2);
    for (int e = 0; e < 10; e++) begin
      logic [8:0] want;
      load_in[3] = (e == 5);
      val_in[3]  = 32'hE;
      @(negedge clock);
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (obs[k] !== exp_v[k]) begin
          n_errors++; $display("FAIL single_model dut%0d e=%0d got=%h exp=%h", k, e, obs[k], exp_v[k]);
        end
      end
      want = {(e >= 6) ? 7'h79 : 7'h3F, 1'b1, 1'b1};
      n_checks++;
      if ({b3.Seg, b3.DigitEn, b3.FrameTick} !== want) begin
        n_errors++; $display("FAIL single e=%0d got=%h exp=%h", e, {b3.Seg, b3.DigitEn, b3.FrameTick}, want);
      end
    end
    load_in[3] = 1'b0;
  endtask

  // Reset mid-frame with a pending load: the pending value must be dropped.
  task automatic test_reset_mid();
    do_reset(2);
    for (int e = 0; e < 24; e++) begin
      load_in[0] = (e == 0) || (e == 20);
      val_in[0]  = (e == 0) ? 32'h1234 : 32'h9999;
      reset      = (e >= 22);
      @(negedge clock);
      if (e >= 22) begin
        n_checks++;
        if ({obs[0], obs[2]} !== {17'h0, 7'h7F, 1'b1, 8'h0F, 1'b0}) begin
          n_errors++; $display("FAIL mid_reset_off e=%0d got=%h/%h", e, obs[0], obs[2]);
        end
      end
    end
    load_in[0] = 1'b0;
    reset = 1'b0;
    for (int e = 0; e < 32; e++) begin
      @(negedge clock);
      n_checks++;
      if (obs[0] !== exp_v[0]) begin
        n_errors++; $display("FAIL mid_model e=%0d got=%h exp=%h", e, obs[0], exp_v[0]);
      end
      n_checks++;
      if ({b0.Seg, b0.DigitEn} !== {7'h3F, 4'(1 << ((e % 16) / 4))}) begin
        n_errors++;
        $display("FAIL mid_after e=%0d got=%h exp=%h", e, {b0.Seg, b0.DigitEn}, {7'h3F, 4'(1 << ((e % 16) / 4))});
      end
    end
  endtask

  // Random loads, dots, enables and occasional resets on all instances.
  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      reset = ($urandom_range(0, 99) == 0);
      for (int k = 0; k < 4; k++) begin
        load_in[k] = ($urandom_range(0, 5) == 0);
        val_in[k]  = $urandom();
        dot_in[k]  = 8'($urandom());
        en_in[k]   = ($urandom_range(0, 7) != 0);
      end
      @(negedge clock);
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (obs[k] !== exp_v[k]) begin
          n_errors++; $display("FAIL rand_model dut%0d c=%0d got=%h exp=%h", k, c, obs[k], exp_v[k]);
        end
      end
    end
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      load_in[k] = 1'b0; en_in[k] = 1'b1;
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      val_in[k] = '0; dot_in[k] = '0; load_in[k] = 1'b0; en_in[k] = 1'b1;
    end
    test_reset();
    test_scan();
    test_blanking();
    test_polarity();
    test_single();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
